// File: rtl/sdram_wb_bridge.sv
// Wishbone-to-SDRAM-controller handshake bridge: latches one request, tracks controller
// init/busy via ctl_ready, captures read data and forces completion on a bus timeout.
module sdram_wb_bridge #(
    parameter int ACC_WIN = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk_p,
    input  logic        i_reset_n,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_sel,
    input  logic [21:1] i_wb_adr,
    input  logic [15:0] i_wb_dat_i,
    output logic [15:0] o_wb_dat_o,
    output logic        o_wb_ack,
    output logic        o_sdram_ready,
    output logic        o_timeout_err,
    output logic        o_ctl_rd,
    output logic        o_ctl_we,
    output logic [1:0]  o_ctl_wtbt,
    output logic [24:0] o_ctl_addr,
    output logic [15:0] o_ctl_din,
    input  logic [15:0] i_ctl_dout,
    input  logic        i_ctl_ready
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_REQ  = 3'd2,
        ST_BUSY = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] ACC_LAST = 8'(ACC_WIN - 1);
    localparam logic [7:0] TO_MAX   = 8'(TIMEOUT);

    state_t     r_state;
    logic       r_we;
    logic       r_rdy_seen;
    logic [7:0] r_acc_cnt;
    logic [7:0] r_to_cnt;

    // Bridge FSM; every output is a register so reset drops the request asynchronously.
    always_ff @(posedge i_clk_p or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_INIT;
            r_we          <= 1'b0;
            r_rdy_seen    <= 1'b0;
            r_acc_cnt     <= 8'd0;
            r_to_cnt      <= 8'd0;
            o_wb_dat_o    <= 16'h0000;
            o_wb_ack      <= 1'b0;
            o_sdram_ready <= 1'b0;
            o_timeout_err <= 1'b0;
            o_ctl_rd      <= 1'b0;
            o_ctl_we      <= 1'b0;
            o_ctl_wtbt    <= 2'b00;
            o_ctl_addr    <= 25'd0;
            o_ctl_din     <= 16'h0000;
        end else begin
            o_wb_ack <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    // Controller must report ready on two consecutive samples.
                    if (i_ctl_ready) begin
                        if (r_rdy_seen) begin
                            o_sdram_ready <= 1'b1;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_rdy_seen <= 1'b1;
                        end
                    end else begin
                        r_rdy_seen <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (i_wb_stb) begin
                        r_we       <= i_wb_we;
                        o_ctl_addr <= {3'b000, i_wb_adr, 1'b0};
                        o_ctl_din  <= i_wb_dat_i;
                        o_ctl_wtbt <= i_wb_we ? i_wb_sel : 2'b00;
                        o_ctl_rd   <= ~i_wb_we;
                        o_ctl_we   <= i_wb_we;
                        r_acc_cnt  <= 8'd0;
                        r_to_cnt   <= 8'd0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ, ST_BUSY: begin
                    if (r_to_cnt == TO_MAX) begin
                        o_ctl_rd      <= 1'b0;
                        o_ctl_we      <= 1'b0;
                        o_timeout_err <= 1'b1;
                        if (!r_we) begin
                            o_wb_dat_o <= 16'hFFFF;
                        end
                        o_wb_ack <= i_wb_stb;
                        r_state  <= ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                        if (r_state == ST_REQ) begin
                            // A controller that never drops ready finished inside the window.
                            if (!i_ctl_ready || (r_acc_cnt == ACC_LAST)) begin
                                o_ctl_rd <= 1'b0;
                                o_ctl_we <= 1'b0;
                                r_state  <= ST_BUSY;
                            end else begin
                                r_acc_cnt <= r_acc_cnt + 8'd1;
                            end
                        end else if (i_ctl_ready) begin
                            if (!r_we) begin
                                o_wb_dat_o <= i_ctl_dout;
                            end
                            o_wb_ack <= i_wb_stb;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Randomized bench for sdram_wb_bridge: a behavioural SDRAM controller plus a word-level
// reference memory predict every acknowledge, latency and read value.
module tb_sdram_wb_bridge;

    localparam int ACC_WIN = 4;
    localparam int TIMEOUT = 255;

    logic        clk_p = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [1:0]  wb_sel = 2'b00;
    logic [20:0] wb_adr = 21'd0;
    logic [15:0] wb_dat_i = 16'h0000;
    logic [15:0] wb_dat_o;
    logic        wb_ack;
    logic        sdram_ready;
    logic        timeout_err;
    logic        ctl_rd;
    logic        ctl_we;
    logic [1:0]  ctl_wtbt;
    logic [24:0] ctl_addr;
    logic [15:0] ctl_din;
    logic [15:0] ctl_dout = 16'h0000;
    logic        ctl_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Controller model: 0 = accept then busy cm_n cycles, 1 = never drops ready, 2 = hangs.
    int          cm_mode = 0;
    int          cm_n = 1;
    int          cm_left = 0;
    bit          cm_prev_req = 1'b0;
    bit          cm_taken = 1'b0;
    logic [15:0] cm_rdata = 16'h0000;
    logic [15:0] cm_mem [int];
    logic [15:0] ref_mem [int];
    logic [15:0] last_rd = 16'h0000;

    sdram_wb_bridge #(.ACC_WIN(ACC_WIN), .TIMEOUT(TIMEOUT)) dut (
        .i_clk_p      (clk_p),
        .i_reset_n    (reset_n),
        .i_wb_stb     (wb_stb),
        .i_wb_we      (wb_we),
        .i_wb_sel     (wb_sel),
        .i_wb_adr     (wb_adr),
        .i_wb_dat_i   (wb_dat_i),
        .o_wb_dat_o   (wb_dat_o),
        .o_wb_ack     (wb_ack),
        .o_sdram_ready(sdram_ready),
        .o_timeout_err(timeout_err),
        .o_ctl_rd     (ctl_rd),
        .o_ctl_we     (ctl_we),
        .o_ctl_wtbt   (ctl_wtbt),
        .o_ctl_addr   (ctl_addr),
        .o_ctl_din    (ctl_din),
        .i_ctl_dout   (ctl_dout),
        .i_ctl_ready  (ctl_ready)
    );

    always #5 clk_p = ~clk_p;

    function automatic logic [15:0] ref_read(input logic [20:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 16'h0000;
    endfunction

    function automatic void ref_write(input logic [20:0] a, input logic [15:0] d, input logic [1:0] s);
        logic [15:0] w;
        w = ref_read(a);
        if (s[0]) w[7:0] = d[7:0];
        if (s[1]) w[15:8] = d[15:8];
        ref_mem[int'(a)] = w;
    endfunction

    // Controller reacts one cycle after it first sees a request, like a registered controller.
    task automatic ctl_step();
        logic        req;
        int          idx;
        logic [15:0] word;
        req = ctl_rd | ctl_we;
        if (cm_left > 0) begin
            cm_left--;
            if (cm_left == 0) begin
                ctl_ready = 1'b1;
                ctl_dout  = cm_rdata;
            end
        end else if (cm_prev_req && !cm_taken) begin
            cm_taken = 1'b1;
            idx  = int'(ctl_addr[21:1]);
            word = cm_mem.exists(idx) ? cm_mem[idx] : 16'h0000;
            if (ctl_we) begin
                if (ctl_wtbt[0]) word[7:0] = ctl_din[7:0];
                if (ctl_wtbt[1]) word[15:8] = ctl_din[15:8];
                cm_mem[idx] = word;
            end
            cm_rdata = word;
            if (cm_mode == 1) begin
                ctl_dout = cm_rdata;
            end else begin
                ctl_ready = 1'b0;
                ctl_dout  = 16'($urandom);
                cm_left   = (cm_mode == 2) ? 32'h7FFF_FFFF : cm_n;
            end
        end
        if (!req) cm_taken = 1'b0;
        cm_prev_req = req;
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
        ctl_step();
    endtask

    task automatic preload(input logic [20:0] a, input logic [15:0] d);
        cm_mem[int'(a)]  = d;
        ref_mem[int'(a)] = d;
    endtask

    // One master transaction; lat counts stb-high cycles including the ack cycle.
    task automatic do_txn(input logic we, input logic [20:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input int abort_at, input int limit,
                          input bit keep_stb, output int lat, output int req_cyc,
                          output bit acked, output logic [15:0] rdat, output logic [24:0] cap_addr);
        logic [24:0] exp_addr;
        logic [1:0]  exp_wtbt;
        int          edges;
        bit          done;
        exp_addr = {3'b000, adr, 1'b0};
        exp_wtbt = we ? sel : 2'b00;
        wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_stb = 1'b1;
        lat = 0; req_cyc = 0; acked = 1'b0; rdat = 16'h0000; cap_addr = 25'd0;
        edges = 0; done = 1'b0;
        while (!done) begin
            tick();
            edges++;
            checks++;
            if (ctl_rd && ctl_we) begin
                errors++;
                $display("FAIL rd_we_both got rd=%b we=%b exp never both", ctl_rd, ctl_we);
            end
            if (ctl_rd || ctl_we) begin
                if (req_cyc == 0) cap_addr = ctl_addr;
                req_cyc++;
                checks++;
                if (ctl_rd !== ~we || ctl_we !== we || ctl_addr !== exp_addr ||
                    ctl_wtbt !== exp_wtbt || (we && ctl_din !== dat)) begin
                    errors++;
                    $display("FAIL req_fields got rd=%b we=%b addr=%h wtbt=%b din=%h exp we=%b addr=%h wtbt=%b din=%h",
                             ctl_rd, ctl_we, ctl_addr, ctl_wtbt, ctl_din, we, exp_addr, exp_wtbt, dat);
                end
                wb_adr   = 21'($urandom);
                wb_dat_i = 16'($urandom);
            end
            if (edges == abort_at) wb_stb = 1'b0;
            if (wb_ack) begin
                acked = 1'b1;
                lat   = edges + 1;
                rdat  = wb_dat_o;
                if (!keep_stb) wb_stb = 1'b0;
                done = 1'b1;
            end else if (edges >= limit) begin
                done = 1'b1;
            end
        end
        tick();
        checks++;
        if (wb_ack !== 1'b0 || ctl_rd !== 1'b0 || ctl_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap got ack=%b rd=%b we=%b exp 0 0 0", wb_ack, ctl_rd, ctl_we);
        end
    endtask

    task automatic test_reset();
        cm_mode = 0; cm_left = 0; cm_prev_req = 1'b0; cm_taken = 1'b0;
        ctl_ready = 1'b0; reset_n = 1'b0;
        #12;
        checks++;
        if (wb_dat_o !== 16'h0 || wb_ack !== 1'b0 || sdram_ready !== 1'b0 || timeout_err !== 1'b0 ||
            ctl_rd !== 1'b0 || ctl_we !== 1'b0 || ctl_wtbt !== 2'b00 || ctl_addr !== 25'd0 || ctl_din !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got dat=%h ack=%b rdy=%b terr=%b rd=%b we=%b wtbt=%b addr=%h din=%h exp all 0",
                     wb_dat_o, wb_ack, sdram_ready, timeout_err, ctl_rd, ctl_we, ctl_wtbt, ctl_addr, ctl_din);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wb_stb = (i >= 3 && i < 8) ? 1'b1 : 1'b0;
            wb_we  = i[0];
            tick();
            checks++;
            if (ctl_rd || ctl_we || wb_ack || sdram_ready) begin
                errors++;
                $display("FAIL init_quiet got rd=%b we=%b ack=%b rdy=%b exp 0 0 0 0", ctl_rd, ctl_we, wb_ack, sdram_ready);
            end
        end
        wb_stb = 1'b0;
        ctl_ready = 1'b1;
        tick();
        checks++;
        if (sdram_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early got %b exp 0", sdram_ready);
        end
        tick();
        checks++;
        if (sdram_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise got %b exp 1", sdram_ready);
        end
    endtask

    task automatic test_write();
        int lat, rc; bit ak; logic [15:0] rd; logic [24:0] ca;
        cm_mode = 0; cm_n = 6;
        do_txn(1'b1, 21'h00123, 16'hA5C3, 2'b01, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        ref_write(21'h00123, 16'hA5C3, 2'b01);
        checks++;
        if (!ak || lat != 10 || rc != 2 || ca !== 25'h000246 || rd !== last_rd) begin
            errors++;
            $display("FAIL write_basic got ack=%b lat=%0d req=%0d addr=%h dat_o=%h exp 1 10 2 000246 %h",
                     ak, lat, rc, ca, rd, last_rd);
        end
        cm_n = 2;
        do_txn(1'b0, 21'h00123, 16'h0, 2'b11, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        last_rd = ref_read(21'h00123);
        checks++;
        if (!ak || lat != 6 || rd !== 16'h00C3) begin
            errors++;
            $display("FAIL write_readback got ack=%b lat=%0d dat=%h exp 1 6 00c3", ak, lat, rd);
        end
    endtask

    task automatic test_read_back_to_back();
        int lat, rc; bit ak; logic [15:0] rd; logic [24:0] ca;
        preload(21'h1FFFFF, 16'h1234);
        preload(21'h0ABCDE, 16'h5A5A);
        cm_mode = 0; cm_n = 3;
        do_txn(1'b0, 21'h1FFFFF, 16'hFFFF, 2'b11, 0, 600, 1'b1, lat, rc, ak, rd, ca);
        last_rd = 16'h1234;
        checks++;
        if (!ak || lat != 7 || rc != 2 || rd !== 16'h1234 || ca !== 25'h3FFFFE) begin
            errors++;
            $display("FAIL read_basic got ack=%b lat=%0d req=%0d dat=%h addr=%h exp 1 7 2 1234 3ffffe", ak, lat, rc, rd, ca);
        end
        cm_n = 4;
        do_txn(1'b0, 21'h0ABCDE, 16'h0, 2'b10, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        last_rd = 16'h5A5A;
        checks++;
        if (!ak || lat != 8 || rc != 2 || rd !== 16'h5A5A) begin
            errors++;
            $display("FAIL read_b2b got ack=%b lat=%0d req=%0d dat=%h exp 1 8 2 5a5a", ak, lat, rc, rd);
        end
    endtask

    task automatic test_fast_accept();
        int lat, rc; bit ak; logic [15:0] rd; logic [24:0] ca;
        preload(21'h000777, 16'hC0DE);
        cm_mode = 1;
        do_txn(1'b0, 21'h000777, 16'h0, 2'b11, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        last_rd = 16'hC0DE;
        checks++;
        if (!ak || rc != ACC_WIN || lat != ACC_WIN + 3 || rd !== 16'hC0DE) begin
            errors++;
            $display("FAIL fast_accept got ack=%b req=%0d lat=%0d dat=%h exp 1 %0d %0d c0de", ak, rc, lat, rd, ACC_WIN, ACC_WIN + 3);
        end
        cm_mode = 0;
    endtask

    task automatic test_random();
        int lat, rc, exp_lat, exp_rc; bit ak; logic [15:0] rd, d, exp_d; logic [24:0] ca;
        logic [20:0] pool [4];
        logic [20:0] a; logic [1:0] s; logic w;
        for (int i = 0; i < 4; i++) pool[i] = 21'($urandom);
        for (int t = 0; t < 16; t++) begin
            a = pool[$urandom_range(0, 3)];
            w = 1'($urandom);
            d = 16'($urandom);
            s = 2'($urandom);
            cm_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            cm_n = $urandom_range(1, 5);
            exp_lat = (cm_mode == 1) ? ACC_WIN + 3 : cm_n + 4;
            exp_rc  = (cm_mode == 1) ? ACC_WIN : 2;
            do_txn(w, a, d, s, 0, 600, 1'b0, lat, rc, ak, rd, ca);
            if (w) begin
                ref_write(a, d, s);
                exp_d = last_rd;
            end else begin
                exp_d = ref_read(a);
                last_rd = exp_d;
            end
            checks++;
            if (!ak || lat != exp_lat || rc != exp_rc || rd !== exp_d) begin
                errors++;
                $display("FAIL rand_txn%0d got ack=%b lat=%0d req=%0d dat=%h exp 1 %0d %0d %h", t, ak, lat, rc, rd, exp_lat, exp_rc, exp_d);
            end
        end
        cm_mode = 0;
    endtask

    task automatic test_abort();
        int lat, rc; bit ak; logic [15:0] rd; logic [24:0] ca;
        cm_mode = 0; cm_n = 8;
        do_txn(1'b1, 21'h012345, 16'hBEEF, 2'b11, 4, 16, 1'b0, lat, rc, ak, rd, ca);
        ref_write(21'h012345, 16'hBEEF, 2'b11);
        checks++;
        if (ak) begin
            errors++;
            $display("FAIL abort_no_ack got ack=1 lat=%0d exp no ack", lat);
        end
        cm_n = 2;
        do_txn(1'b0, 21'h012345, 16'h0, 2'b11, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        last_rd = ref_read(21'h012345);
        checks++;
        if (!ak || lat != 6 || rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL abort_next got ack=%b lat=%0d dat=%h exp 1 6 beef", ak, lat, rd);
        end
    endtask

    task automatic test_timeout();
        int lat, rc; bit ak; logic [15:0] rd; logic [24:0] ca;
        preload(21'h000100, 16'h4242);
        cm_mode = 2;
        do_txn(1'b0, 21'h000100, 16'h0, 2'b11, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        last_rd = 16'hFFFF;
        checks++;
        if (!ak || lat < TIMEOUT + 1 || lat > TIMEOUT + 4 || rd !== 16'hFFFF || timeout_err !== 1'b1 || rc != 2) begin
            errors++;
            $display("FAIL timeout got ack=%b lat=%0d dat=%h terr=%b req=%0d exp 1 %0d..%0d ffff 1 2",
                     ak, lat, rd, timeout_err, rc, TIMEOUT + 1, TIMEOUT + 4);
        end
        cm_mode = 0; cm_left = 0; ctl_ready = 1'b1; cm_n = 3;
        do_txn(1'b1, 21'h000100, 16'h9876, 2'b10, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        ref_write(21'h000100, 16'h9876, 2'b10);
        checks++;
        if (!ak || lat != 7 || timeout_err !== 1'b1 || rd !== 16'hFFFF) begin
            errors++;
            $display("FAIL timeout_sticky got ack=%b lat=%0d terr=%b dat=%h exp 1 7 1 ffff", ak, lat, timeout_err, rd);
        end
    endtask

    task automatic test_reset_busy();
        int lat, rc; bit ak; logic [15:0] rd; logic [24:0] ca;
        cm_mode = 0; cm_n = 10;
        wb_we = 1'b0; wb_adr = 21'h000321; wb_sel = 2'b11; wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset_n = 1'b0;
        wb_stb = 1'b0;
        #1;
        checks++;
        if (ctl_rd !== 1'b0 || ctl_we !== 1'b0 || sdram_ready !== 1'b0 || wb_ack !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got rd=%b we=%b rdy=%b ack=%b terr=%b exp all 0", ctl_rd, ctl_we, sdram_ready, wb_ack, timeout_err);
        end
        cm_left = 0; cm_prev_req = 1'b0; cm_taken = 1'b0; ctl_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (sdram_ready !== 1'b1) begin
            errors++;
            $display("FAIL reinit got %b exp 1", sdram_ready);
        end
        cm_mode = 1;
        wb_we = 1'b1; wb_adr = 21'h000055; wb_dat_i = 16'h1111; wb_sel = 2'b11; wb_stb = 1'b1;
        tick();
        checks++;
        if (ctl_we !== 1'b1) begin
            errors++;
            $display("FAIL req_before_reset got %b exp 1", ctl_we);
        end
        tick();
        #2;
        reset_n = 1'b0;
        wb_stb = 1'b0;
        #1;
        checks++;
        if (ctl_rd !== 1'b0 || ctl_we !== 1'b0 || sdram_ready !== 1'b0 || wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_async got rd=%b we=%b rdy=%b ack=%b exp 0 0 0 0", ctl_rd, ctl_we, sdram_ready, wb_ack);
        end
        cm_mode = 0; cm_left = 0; cm_prev_req = 1'b0; cm_taken = 1'b0; ctl_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        cm_n = 2;
        do_txn(1'b0, 21'h000123, 16'h0, 2'b11, 0, 600, 1'b0, lat, rc, ak, rd, ca);
        checks++;
        if (!ak || lat != 6 || rd !== ref_read(21'h000123)) begin
            errors++;
            $display("FAIL after_reset got ack=%b lat=%0d dat=%h exp 1 6 %h", ak, lat, rd, ref_read(21'h000123));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back_to_back();
        test_fast_accept();
        test_random();
        test_abort();
        test_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion exp finish within 2 ms");
        $fatal(1);
    end

endmodule
